// File: rtl/window_line_buffer_pkg.sv
// Shared constants and helpers for the convolution datapath blocks.
package cnn_pkg;

  localparam int unsigned DATA_W_DEFAULT = 8;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return (r == 0) ? 1 : r;
  endfunction

  // Flat element index of window position (r,c); r=0 is the oldest row.
  function automatic int unsigned win_idx(input int unsigned r, input int unsigned c,
                                          input int unsigned k);
    return r * k + c;
  endfunction

  function automatic int unsigned win_count(input int unsigned h, input int unsigned w,
                                            input int unsigned k);
    return (h - k + 1) * (w - k + 1);
  endfunction

endpackage

// File: rtl/window_line_buffer_if.sv
// Pixel-in / window-out stream bundle for window_line_buffer.
interface window_line_buffer_if
  import cnn_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT,
  parameter int unsigned K      = 3,
  parameter int unsigned ROW_W  = 8,
  parameter int unsigned COL_W  = 8
);
  logic                    in_valid;
  logic                    in_ready;
  logic                    in_sof;
  logic [DATA_W-1:0]       in_pixel;
  logic                    out_valid;
  logic                    out_ready;
  logic [K*K*DATA_W-1:0]   out_win;
  logic [ROW_W-1:0]        out_row;
  logic [COL_W-1:0]        out_col;
  logic                    out_last;

  modport master (
    output in_valid, in_sof, in_pixel, out_ready,
    input  in_ready, out_valid, out_win, out_row, out_col, out_last
  );

  modport slave (
    input  in_valid, in_sof, in_pixel, out_ready,
    output in_ready, out_valid, out_win, out_row, out_col, out_last
  );
endinterface

// File: rtl/window_line_buffer_lb_row_ram.sv
// One image row of delay: IMG_W x DATA_W memory with registered read port.
module lb_row_ram
  import cnn_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT,
  parameter int unsigned DEPTH  = 224,
  parameter int unsigned AW     = 8
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/window_line_buffer.sv
// KxK sliding-window generator over a raster pixel stream (valid convolution).
module window_line_buffer
  import cnn_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT,
  parameter int unsigned IMG_W  = 224,
  parameter int unsigned IMG_H  = 224,
  parameter int unsigned K      = 3
) (
  input logic clk,
  input logic rst,
  window_line_buffer_if.slave bus
);
  localparam int unsigned ROW_W = clog2(IMG_H);
  localparam int unsigned COL_W = clog2(IMG_W);
  localparam int unsigned WIN_W = K * K * DATA_W;

  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_FIRST = COL_W'(K - 1);
  localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(K - 1);

  logic [COL_W-1:0]    col, col_eff, col_nx, rd_addr;
  logic [ROW_W-1:0]    row, row_eff, row_nx;
  logic                accept, win_ok;
  logic [WIN_W-1:0]    win, win_nx;
  logic [K*DATA_W-1:0] col_new;

  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    col_eff = bus.in_sof ? '0 : col;
    row_eff = bus.in_sof ? '0 : row;
    col_nx  = col_eff + COL_W'(1);
    row_nx  = row_eff;
    if (col_eff == COL_LAST) begin
      col_nx = '0;
      row_nx = (row_eff == ROW_LAST) ? '0 : row_eff + ROW_W'(1);
    end
    // Read port runs one pixel ahead so the next column's taps are ready at its accept.
    rd_addr = accept ? col_nx : col;
    win_ok  = accept && (row_eff >= ROW_FIRST) && (col_eff >= COL_FIRST);
  end

  assign col_new[(K-1)*DATA_W +: DATA_W] = bus.in_pixel;

  // Row k's tap is read from memory k and the newer row k+1 is written back in its place.
  for (genvar k = 0; k < K - 1; k++) begin : g_row
    logic [DATA_W-1:0] tap;
    lb_row_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (IMG_W),
      .AW     (COL_W)
    ) u_ram (
      .clk     (clk),
      .wr_en   (accept),
      .wr_addr (col_eff),
      .wr_data (col_new[(k+1)*DATA_W +: DATA_W]),
      .rd_addr (rd_addr),
      .rd_data (tap)
    );
    assign col_new[k*DATA_W +: DATA_W] = tap;
  end

  always_comb begin
    win_nx = win;
    for (int unsigned r = 0; r < K; r++) begin
      for (int unsigned c = 0; c < K - 1; c++) begin
        win_nx[win_idx(r, c, K)*DATA_W +: DATA_W] = win[win_idx(r, c + 1, K)*DATA_W +: DATA_W];
      end
      win_nx[win_idx(r, K - 1, K)*DATA_W +: DATA_W] = col_new[r*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col           <= '0;
      row           <= '0;
      win           <= '0;
      bus.out_valid <= 1'b0;
      bus.out_win   <= '0;
      bus.out_row   <= '0;
      bus.out_col   <= '0;
      bus.out_last  <= 1'b0;
    end else begin
      if (accept) begin
        col <= col_nx;
        row <= row_nx;
        win <= win_nx;
      end
      if (win_ok) begin
        bus.out_valid <= 1'b1;
        bus.out_win   <= win_nx;
        bus.out_row   <= row_eff - ROW_FIRST;
        bus.out_col   <= col_eff - COL_FIRST;
        bus.out_last  <= (row_eff == ROW_LAST) && (col_eff == COL_LAST);
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_window_line_buffer.sv
// Checks a K=3 and a K=5 window_line_buffer (8x6 image) against an image-array reference.
module tb_window_line_buffer;
  import cnn_pkg::*;

  localparam int W = 8;
  localparam int H = 6;

  typedef struct {
    logic [255:0] win;
    int           row;
    int           col;
    bit           last;
  } win_t;

  typedef struct {
    int n;
    int row;
    int col;
    bit last;
    int tl;
    int br;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  window_line_buffer_if #(.DATA_W(8), .K(3), .ROW_W(3), .COL_W(3)) b3 ();
  window_line_buffer_if #(.DATA_W(8), .K(5), .ROW_W(3), .COL_W(3)) b5 ();

  window_line_buffer #(.DATA_W(8), .IMG_W(W), .IMG_H(H), .K(3)) u_k3 (
    .clk (clk), .rst (rst), .bus (b3.slave));
  window_line_buffer #(.DATA_W(8), .IMG_W(W), .IMG_H(H), .K(5)) u_k5 (
    .clk (clk), .rst (rst), .bus (b5.slave));

  // K=5 instance accepts exactly the pixels the K=3 instance accepts.
  assign b5.in_valid  = b3.in_valid && b3.in_ready;
  assign b5.in_sof    = b3.in_sof;
  assign b5.in_pixel  = b3.in_pixel;
  assign b5.out_ready = 1'b1;

  int total = 0;
  int bad   = 0;

  win_t q0[$], q1[$], cap0[$], cap1[$], t1ref[$];
  int   nwin[2], nlast[2];
  bit   pl[2], hd[2];
  logic [255:0] hw[2];
  int   hm[2];
  logic [7:0] img[H][W];
  int   p = 0;
  int   mode = 0;
  int   cyc = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] mk_win(input int k, input int r, input int c);
    logic [255:0] w;
    w = '0;
    for (int rr = 0; rr < k; rr++)
      for (int cc = 0; cc < k; cc++)
        w[(rr*k+cc)*8 +: 8] = img[r-k+1+rr][c-k+1+cc];
    return w;
  endfunction

  task automatic mon(input int s, input logic ov, input logic ordy, input logic [255:0] w,
                     input int row, input int col, input logic last);
    win_t  e, a;
    int    meta;
    string pf;
    pf   = (s == 0) ? "k3_" : "k5_";
    meta = (int'(ov) << 16) | (int'(last) << 12) | (row << 4) | col;
    if (pl[s]) begin
      chk({pf, "load_latency"}, 256'(ov), 256'(1));
      pl[s] = 0;
    end
    if (hd[s]) begin
      chk({pf, "hold_win"}, w, hw[s]);
      chk({pf, "hold_meta"}, 256'(meta), 256'(hm[s]));
      hd[s] = 0;
    end
    if (ov && ordy) begin
      if ((s == 0 && q0.size() == 0) || (s == 1 && q1.size() == 0)) begin
        chk({pf, "spurious_window"}, 256'(1), 256'(0));
      end else begin
        if (s == 0) e = q0.pop_front(); else e = q1.pop_front();
        chk({pf, "win"}, w, e.win);
        chk({pf, "row"}, 256'(row), 256'(e.row));
        chk({pf, "col"}, 256'(col), 256'(e.col));
        chk({pf, "last"}, 256'(last), 256'(e.last));
        a = '{w, row, col, last};
        if (s == 0) cap0.push_back(a); else cap1.push_back(a);
        nwin[s]++;
        if (last) nlast[s]++;
      end
    end else if (ov) begin
      hd[s] = 1;
      hw[s] = w;
      hm[s] = meta;
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(0, b3.out_valid, b3.out_ready, 256'(b3.out_win), int'(b3.out_row), int'(b3.out_col), b3.out_last);
      mon(1, b5.out_valid, b5.out_ready, 256'(b5.out_win), int'(b5.out_row), int'(b5.out_col), b5.out_last);
      chk("in_ready", 256'(b3.in_ready), 256'(!b3.out_valid || b3.out_ready));
      if (b3.in_valid && b3.in_ready) begin
        int r, c, k;
        if (b3.in_sof) p = 0;
        r = p / W;
        c = p % W;
        img[r][c] = b3.in_pixel;
        for (int s = 0; s < 2; s++) begin
          k = (s == 0) ? 3 : 5;
          if (r >= k - 1 && c >= k - 1) begin
            win_t e;
            e = '{mk_win(k, r, c), r - k + 1, c - k + 1, (r == H - 1) && (c == W - 1)};
            if (s == 0) q0.push_back(e); else q1.push_back(e);
            pl[s] = 1;
          end
        end
        p = (p + 1) % (W * H);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    cyc++;
    case (mode)
      0:       b3.out_ready = 1'b1;
      1:       b3.out_ready = (cyc % 3 == 0);
      default: b3.out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic clear_caps();
    cap0.delete(); cap1.delete();
    nwin[0] = 0; nwin[1] = 0; nlast[0] = 0; nlast[1] = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_valid_k3", 256'(b3.out_valid), 256'(0));
    chk("rst_valid_k5", 256'(b5.out_valid), 256'(0));
    q0.delete(); q1.delete();
    pl[0] = 0; pl[1] = 0; hd[0] = 0; hd[1] = 0;
    p = 0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic send_px(input logic [7:0] pix, input bit sof, input bit gaps);
    bit acc;
    if (gaps && $urandom_range(0, 3) == 0) begin
      b3.in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    b3.in_valid = 1'b1;
    b3.in_pixel = pix;
    b3.in_sof   = sof;
    acc = 0;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      acc = b3.in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    if (!acc) chk("accept_timeout", 256'(0), 256'(1));
    b3.in_valid = 1'b0;
    b3.in_sof   = 1'b0;
  endtask

  task automatic send_frame(input int n, input int base, input bit sof_first, input bit gaps);
    for (int i = 0; i < n; i++) send_px(8'(base + i), sof_first && (i == 0), gaps);
  endtask

  task automatic drain();
    b3.in_valid = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(posedge clk);
      #2;
      if (q0.size() == 0 && q1.size() == 0 && !b3.out_valid && !b5.out_valid) break;
    end
    chk("drain", 256'(q0.size() + q1.size()), 256'(0));
  endtask

  initial begin
    vec_t tbl[5];
    logic [71:0] first_win;
    int bad_mix, lo;

    tbl[0] = '{0, 0, 0, 0, 0, 18};
    tbl[1] = '{1, 0, 1, 0, 1, 19};
    tbl[2] = '{5, 0, 5, 0, 5, 23};
    tbl[3] = '{6, 1, 0, 0, 8, 26};
    tbl[4] = '{23, 3, 5, 1, 29, 47};
    first_win = {8'd18, 8'd17, 8'd16, 8'd10, 8'd9, 8'd8, 8'd2, 8'd1, 8'd0};

    b3.in_valid = 1'b0;
    b3.in_sof   = 1'b0;
    b3.in_pixel = '0;
    do_reset();
    chk("reset_out_valid", 256'(b3.out_valid), 256'(0));
    chk("reset_out_win", 256'(b3.out_win), 256'(0));
    chk("reset_out_row", 256'(b3.out_row), 256'(0));
    chk("reset_out_col", 256'(b3.out_col), 256'(0));
    chk("reset_out_last", 256'(b3.out_last), 256'(0));

    // Basic ramp, no backpressure, no in_sof.
    mode = 0;
    clear_caps();
    send_frame(W * H, 0, 0, 0);
    drain();
    chk("basic_k3_count", 256'(nwin[0]), 256'(win_count(H, W, 3)));
    chk("basic_k5_count", 256'(nwin[1]), 256'(8));
    chk("basic_k3_lasts", 256'(nlast[0]), 256'(1));
    chk("basic_k5_lasts", 256'(nlast[1]), 256'(1));
    if (cap0.size() == 24) begin
      chk("first_window", cap0[0].win, 256'(first_win));
      for (int i = 0; i < 5; i++) begin
        chk("tbl_row", 256'(cap0[tbl[i].n].row), 256'(tbl[i].row));
        chk("tbl_col", 256'(cap0[tbl[i].n].col), 256'(tbl[i].col));
        chk("tbl_last", 256'(cap0[tbl[i].n].last), 256'(tbl[i].last));
        chk("tbl_tl", 256'(cap0[tbl[i].n].win[7:0]), 256'(tbl[i].tl));
        chk("tbl_br", 256'(cap0[tbl[i].n].win[71:64]), 256'(tbl[i].br));
      end
    end
    if (cap1.size() == 8) begin
      chk("k5_elem44", 256'(cap1[0].win[192 +: 8]), 256'(36));
      for (int i = 0; i < 8; i++) begin
        chk("k5_col_seq", 256'(cap1[i].col), 256'(i % 4));
        chk("k5_row_seq", 256'(cap1[i].row), 256'(i / 4));
      end
    end
    t1ref = cap0;

    // Backpressure: out_ready high one cycle in three.
    mode = 1;
    clear_caps();
    send_frame(W * H, 0, 1, 0);
    drain();
    chk("bp_count", 256'(nwin[0]), 256'(24));
    if (cap0.size() == 24 && t1ref.size() == 24)
      for (int i = 0; i < 24; i++) chk("bp_same_seq", cap0[i].win, t1ref[i].win);

    // Mid-frame in_sof after 20 pixels of an old frame.
    mode = 0;
    clear_caps();
    send_frame(20, 0, 1, 0);
    send_frame(W * H, 100, 1, 0);
    drain();
    chk("sof_k3_count", 256'(nwin[0]), 256'(26));
    chk("sof_k5_count", 256'(nwin[1]), 256'(8));
    bad_mix = 0;
    foreach (cap0[i]) begin
      lo = 0;
      for (int e = 0; e < 9; e++) if (cap0[i].win[e*8 +: 8] < 8'd100) lo++;
      if (lo != 0 && lo != 9) bad_mix++;
    end
    chk("sof_no_mix", 256'(bad_mix), 256'(0));
    if (cap0.size() > 2) begin
      chk("sof_first_new_pos", 256'({cap0[2].row, cap0[2].col}), 256'(0));
      chk("sof_first_new_tl", 256'(cap0[2].win[7:0]), 256'(100));
    end

    // Reset during row 3, then a plain ramp without in_sof.
    send_frame(28, 0, 1, 0);
    chk("pre_rst_valid", 256'(b3.out_valid), 256'(1));
    do_reset();
    clear_caps();
    send_frame(W * H, 0, 0, 0);
    drain();
    chk("rst_restart_count", 256'(nwin[0]), 256'(24));
    if (cap0.size() == 24)
      for (int i = 0; i < 24; i++) chk("rst_same_seq", cap0[i].win, t1ref[i].win);

    // Two frames back to back.
    clear_caps();
    send_frame(W * H, 0, 1, 0);
    send_frame(W * H, 50, 1, 0);
    drain();
    chk("b2b_count", 256'(nwin[0]), 256'(48));
    chk("b2b_lasts", 256'(nlast[0]), 256'(2));
    chk("b2b_k5_lasts", 256'(nlast[1]), 256'(2));

    // Random data, gaps, out_ready and occasional in_sof.
    mode = 2;
    clear_caps();
    for (int i = 0; i < 250; i++)
      send_px(8'($urandom), $urandom_range(0, 99) == 0, 1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
